// File: rtl/cnn_pkg.sv
// Types and helpers shared by convolution_layer and the stages downstream of it.
package cnn_pkg;
  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t relu(input sample_t x);
    return x[DATA_W-1] ? '0 : x;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// Half-width row buffer holding the horizontal pair maxima of the even row.
module pool_line_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is never cleared: each entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2/stride-2 max-pool over a raster-ordered feature map.
module relu_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] conv_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              out_valid,
  output logic              frame_done
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [DATA_W-1:0] h_q, pool_q;
  logic              ov_q, fd_q;

  logic [DATA_W-1:0] r, m, lb_rd, win_max;
  logic [AW-1:0]     lb_addr;
  logic              col_last, row_last, lb_we;

  assign r        = relu(sample_t'(conv_in));
  assign m        = (h_q > r) ? h_q : r;
  assign win_max  = (lb_rd > m) ? lb_rd : m;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign lb_addr  = AW'(col_q >> 1);
  assign lb_we    = in_valid & col_q[0] & ~row_q[0];

  pool_line_buffer #(.DATA_W(DATA_W), .DEPTH(LB_DEPTH), .AW(AW)) u_lb (
    .clk     (clk),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (m),
    .rdata_o (lb_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      h_q    <= '0;
      pool_q <= '0;
      ov_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      fd_q <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (!col_q[0]) begin
          h_q <= r;
        end else if (row_q[0]) begin
          // Odd column of an odd row closes a 2x2 window.
          pool_q <= win_max;
          ov_q   <= 1'b1;
          fd_q   <= col_last & row_last;
        end
      end
    end
  end

  assign pool_out   = pool_q;
  assign out_valid  = ov_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Checks a 4x2 and an 8x4 instance against a frame-array reference model.
module tb_relu_maxpool2x2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] conv_a = '0, conv_b = '0;
  logic in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [31:0] pool_a, pool_b;
  logic ov_a, ov_b, fd_a, fd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  relu_maxpool2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .reset(reset), .conv_in(conv_a), .in_valid(in_valid_a),
    .pool_out(pool_a), .out_valid(ov_a), .frame_done(fd_a)
  );

  relu_maxpool2x2 #(.DATA_W(32), .IMG_W(8), .IMG_H(4)) dut_b (
    .clk(clk), .reset(reset), .conv_in(conv_b), .in_valid(in_valid_b),
    .pool_out(pool_b), .out_valid(ov_b), .frame_done(fd_b)
  );

  // Reference model: whole frame kept as an array, window max taken directly.
  logic [31:0] img [2][32];
  int          idx [2];
  logic [31:0] ep  [2];
  logic        ev  [2];
  logic        efd [2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("a_pool", 64'(pool_a), 64'(ep[0]));
    chk("a_vld",  64'(ov_a),   64'(ev[0]));
    chk("a_fd",   64'(fd_a),   64'(efd[0]));
    chk("b_pool", 64'(pool_b), 64'(ep[1]));
    chk("b_vld",  64'(ov_b),   64'(ev[1]));
    chk("b_fd",   64'(fd_b),   64'(efd[1]));
  endtask

  function automatic logic [31:0] umax(input logic [31:0] x, input logic [31:0] y);
    return (x > y) ? x : y;
  endfunction

  task automatic model_accept(input int s, input logic [31:0] d);
    int w, h, pos, row, col;
    w = (s == 0) ? 4 : 8;
    h = (s == 0) ? 2 : 4;
    pos = idx[s] % (w * h);
    row = pos / w;
    col = pos % w;
    img[s][pos] = d[31] ? 32'd0 : d;
    if ((row % 2 == 1) && (col % 2 == 1)) begin
      ev[s]  = 1'b1;
      ep[s]  = umax(umax(img[s][pos - w - 1], img[s][pos - w]),
                    umax(img[s][pos - 1], img[s][pos]));
      efd[s] = (pos == w * h - 1);
    end
    idx[s]++;
  endtask

  // One clock: check what the previous edge produced, then present the next input.
  task automatic step(input int s, input bit v, input logic [31:0] d);
    @(negedge clk);
    check_outs();
    ev  = '{1'b0, 1'b0};
    efd = '{1'b0, 1'b0};
    in_valid_a = (s == 0) && v;
    in_valid_b = (s == 1) && v;
    conv_a = d;
    conv_b = d;
    if (v) model_accept(s, d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, $urandom);
  endtask

  task automatic model_reset();
    idx = '{0, 0};
    ep  = '{32'd0, 32'd0};
    ev  = '{1'b0, 1'b0};
    efd = '{1'b0, 1'b0};
  endtask

  // Assert reset asynchronously between edges, look at outputs while it is held.
  task automatic do_reset();
    @(negedge clk);
    check_outs();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    check_outs();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] neg_seq [8];
    model_reset();
    neg_seq = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE,
                32'hFFFFFFF8, 32'hFFFFFFFC, 32'h7FFFFFFF, 32'd0};
    #1 check_outs();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) step(0, 1'b1, 32'(i));
    gap(2);
    for (int i = 0; i < 8; i++) step(0, 1'b1, neg_seq[i]);
    gap(1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1'b1, 32'(i));
      gap($urandom_range(3, 1));
    end
    for (int i = 1; i <= 3; i++) step(0, 1'b1, 32'(i + 100));
    do_reset();
    for (int i = 1; i <= 8; i++) step(0, 1'b1, 32'(i));
    for (int i = 10; i <= 17; i++) step(0, 1'b1, 32'(i));
    gap(1);
    for (int i = 0; i < 32; i++) step(1, 1'b1, 32'(i));
    gap(1);

    // Random frames on both instances, mixed extremes, random idle gaps.
    for (int f = 0; f < 16; f++) begin
      int s, n;
      s = f % 2;
      n = (s == 0) ? 8 : 32;
      for (int i = 0; i < n; i++) begin
        logic [31:0] d;
        case ($urandom_range(7, 0))
          0: d = 32'h7FFFFFFF;
          1: d = 32'h80000000;
          2: d = 32'd0;
          default: d = $urandom;
        endcase
        step(s, 1'b1, d);
        if ($urandom_range(3, 0) == 0) gap($urandom_range(2, 1));
      end
    end
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/relu_maxpool2x2.md
# relu_maxpool2x2

Streaming ReLU + 2×2 max-pool (stride 2) stage directly downstream of `convolution_layer`. It consumes the raster-ordered 32-bit convolution results one per valid cycle, with no backpressure, and clamps negatives to zero. It emits one pooled value per 2×2 window, plus a frame-done pulse on the last window of each feature map. A half-width line buffer holds the partial maxima of even rows.

## Interface
- `DATA_W`, default 32: sample width, signed two's complement.
- `IMG_W`, default 8: feature-map width in samples. Must be even and ≥2.
- `IMG_H`, default 8: feature-map height in rows. Must be even and ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `conv_in` input DATA_W: signed convolution result, raster order (row-major, column 0 first).
- `in_valid` input 1: `conv_in` is accepted on each rising edge where this is high. No ready signal exists.
- `pool_out` output DATA_W: pooled value, always ≥0. It is registered.
- `out_valid` output 1: single-cycle qualifier for `pool_out`.
- `frame_done` output 1: one-cycle pulse, coincident with `out_valid` of the last window of a frame.

## Operation
- ReLU: r = (conv_in[DATA_W-1]) ? 0 : conv_in. The max comparisons are unsigned on ReLU'd values.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted samples.
  - `col` wraps to 0 after IMG_W-1, which increments `row`.
  - `row` wraps to 0 after IMG_H-1, which starts a new frame.
- Even `col`: register h ← r.
- Odd `col`: m = max(h, r).
  - Even row: line buffer entry [col>>1] ← m.
  - Odd row: `pool_out` ← max(lb[col>>1], m) and `out_valid` ← 1 on the same edge.
- `frame_done` ← 1 on the accepting edge of sample (row IMG_H-1, col IMG_W-1).
- When `in_valid` is low, nothing changes: counters, h and the line buffer hold. `out_valid` and `frame_done` are 0 the next cycle; `pool_out` holds its last value.
- Line-buffer contents are never cleared. Every entry is written in an even row before it is read in the following odd row.
- Frames run back-to-back with no idle cycle required. Sample 0 of the next frame may arrive on the cycle after the last sample of the previous frame.

## Timing
- Reset (async assert, released synchronously to clk by the system): `col`=0, `row`=0, h=0, `pool_out`=0, `out_valid`=0, `frame_done`=0.
- Reset mid-frame discards the partial frame. The first sample after reset release is treated as (row 0, col 0), and no stale output is ever produced.
- Latency: `out_valid` rises one cycle after the edge that accepts the bottom-right sample of a window (registered output).
- Throughput: one sample per cycle sustained. At most one output per 2 accepted samples, and only in odd rows.
- `out_valid` is never high for two consecutive cycles.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_W` default constant.
  - The `relu` function.
  - The `sample_t` typedef (logic signed [DATA_W-1:0]).
  - This package is shared with `convolution_layer` and later stages.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H), computed locally.
- Sub-module `pool_line_buffer`:
  - IMG_W/2 × DATA_W entries.
  - One synchronous write port and one combinational read port, both addressed by col>>1.
  - No reset on the storage array.
- Top contains the counters, the h register, the compare logic and the output registers.

## Test plan
Use IMG_W=4, IMG_H=2 unless noted.
- Continuous samples 1..8 -> `out_valid` the cycle after sample 6 with `pool_out`=6, and the cycle after sample 8 with `pool_out`=8. `frame_done` is high only with the second output.
- Rows [-3,-1,7,-2] and [-8,-4,32'h7FFFFFFF,0] -> outputs 0 and 32'h7FFFFFFF. Covers the negative clamp and the max-positive edge.
- Samples 1..8 with `in_valid` low for 1–3 random cycles between samples -> same outputs 6 and 8, each exactly one cycle after its accepting edge, and no other `out_valid`.
- 3 samples, reset asserted asynchronously mid-cycle, then samples 1..8 -> `pool_out`=0 and `out_valid`=0 during reset, then exactly the outputs 6 and 8.
- Back-to-back frames 1..8 then 10..17 with no gap -> outputs 6, 8, 15, 17, and `frame_done` with 8 and 17.
- IMG_W=8, IMG_H=4, samples 0..31 -> outputs 9, 11, 13, 15, 25, 27, 29, 31, and `frame_done` with 31.
